// File: rtl/viola_pkg.sv
// rtl/viola_pkg.sv - shared ROB/CDB constants and the completion entry type
package viola_pkg;

    localparam int ROB_TAG_W = 3;
    localparam logic [ROB_TAG_W-1:0] ROB_NULL_TAG = '0;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 is_branch;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo2.sv
// rtl/cdb_fifo2.sv - 2-entry completion queue feeding one CDB requester slot
module cdb_fifo2
    import viola_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic       pause,
    input  cdb_entry_t din,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    cdb_entry_t mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && !flush && !pause && (count != 2'd2);
    assign do_pop  = pop && !flush && !pause && (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (!pause) begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin sharing of the result broadcast bus between units
module cdb_arbiter
    import viola_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = XLEN,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic [NUM_REQ-1:0]        req_is_branch,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic                      cdb_is_branch,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    cdb_entry_t         din  [NUM_REQ];
    cdb_entry_t         head [NUM_REQ];
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   win;
    logic               found;
    logic               advance;

    assign advance   = !pause && !flush;
    assign req_ready = ~full & {NUM_REQ{advance}};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_q
        assign din[g] = '{tag:       req_tag[g*TAG_W +: TAG_W],
                          value:     req_value[g*DATA_W +: DATA_W],
                          is_branch: req_is_branch[g]};
        // Null-tag pushes complete the handshake but are never stored.
        assign push[g] = req_valid[g] && req_ready[g]
                         && (req_tag[g*TAG_W +: TAG_W] != ROB_NULL_TAG);
        assign pop[g]  = found && (win == SRC_W'(g)) && advance;

        cdb_fifo2 u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .flush (flush),
            .pause (pause),
            .din   (din[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = SRC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_value     <= '0;
            cdb_is_branch <= 1'b0;
            cdb_src       <= '0;
            last_grant    <= SRC_W'(NUM_REQ - 1);
        end else if (flush) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
        end else if (!pause) begin
            if (found) begin
                cdb_valid     <= 1'b1;
                cdb_tag       <= head[win].tag;
                cdb_value     <= head[win].value;
                cdb_is_branch <= head[win].is_branch;
                cdb_src       <= win;
                last_grant    <= win;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
            end
        end
    end

endmodule
